// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the datapath word plus the memory arbiter's state set and default limits.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_IACC  = 3'd1,
    ARB_DACC  = 3'd2,
    ARB_IRESP = 3'd3,
    ARB_DRESP = 3'd4,
    ARB_ERR   = 3'd5
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/memory_arbiter_if.sv
// Datapath request/response and RAM-port signals of the memory arbiter, bundled as one interface.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  ihit;
  logic  dhit;
  word_t iload;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_ready;
  logic  mem_error;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_error
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_error
  );

endinterface

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port with data priority,
// a fetch anti-starvation limit and a per-access watchdog that latches a sticky error.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RST,
  memory_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'(ARB_IDLE);
  localparam logic [2:0] S_IACC  = 3'(ARB_IACC);
  localparam logic [2:0] S_DACC  = 3'(ARB_DACC);
  localparam logic [2:0] S_IRESP = 3'(ARB_IRESP);
  localparam logic [2:0] S_DRESP = 3'(ARB_DRESP);
  localparam logic [2:0] S_ERR   = 3'(ARB_ERR);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WD_LIM     = WW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          wr_q, wr_d;
  word_t         addr_q, addr_d;
  word_t         store_q, store_d;
  word_t         iload_q, iload_d;
  word_t         dload_q, dload_d;

  logic d_req, grant_d, grant_i;

  // A pending fetch that has already lost STARVE_MAX times in a row takes the next grant.
  assign d_req   = bus.dREN | bus.dWEN;
  assign grant_d = d_req && !(bus.iREN && (starve_q == STARVE_LIM));
  assign grant_i = !grant_d && bus.iREN;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wd_d     = wd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d = S_DACC;
          wr_d    = bus.dWEN;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wd_d    = '0;
          if (bus.iREN && (starve_q != STARVE_LIM)) starve_d = starve_q + 1'b1;
        end else if (grant_i) begin
          state_d  = S_IACC;
          addr_d   = bus.iaddr;
          wd_d     = '0;
          starve_d = '0;
        end
        if (!bus.iREN) starve_d = '0;
      end
      S_IACC, S_DACC: begin
        // ram_ready is checked first so a completion on the expiry cycle still counts.
        if (bus.ram_ready) begin
          if (state_q == S_IACC) begin
            iload_d = bus.ramload;
            state_d = S_IRESP;
          end else begin
            if (!wr_q) dload_d = bus.ramload;
            state_d = S_DRESP;
          end
        end else if (wd_q == WD_LIM) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_IRESP, S_DRESP: state_d = S_IDLE;
      S_ERR:            state_d = S_ERR;
      default:          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      wd_q     <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  assign bus.ramREN    = (state_q == S_IACC) || ((state_q == S_DACC) && !wr_q);
  assign bus.ramWEN    = (state_q == S_DACC) && wr_q;
  assign bus.ramaddr   = addr_q;
  assign bus.ramstore  = store_q;
  assign bus.ihit      = (state_q == S_IRESP);
  assign bus.dhit      = (state_q == S_DRESP);
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.mem_error = (state_q == S_ERR);

endmodule
